// File: rtl/debug_pkg.sv
// Shared definitions for the debug command path: ASCII constants, print
// request types, the tx_print state encoding and the nibble-to-ASCII map.
package debug_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;

    localparam logic TX_TYPE_BYTE = 1'b0;
    localparam logic TX_TYPE_WORD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } tx_state_t;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/tx_print_if.sv
// Print handshake between the command processors (master) and tx_print (slave).
interface tx_print_if;
    import debug_pkg::*;

    logic        req_tx;
    logic        type_tx;
    logic [31:0] din_tx;
    logic        ack_tx;
    logic        busy;

    modport master (output req_tx, type_tx, din_tx, input  ack_tx, busy);
    modport slave  (input  req_tx, type_tx, din_tx, output ack_tx, busy);

endinterface

// File: rtl/tx_print_uart_tx_byte.sv
// 8N1 byte serializer. A start pulse latches the byte and drives the start
// bit on the same edge; done pulses for one cycle when the stop bit ends.
module uart_tx_byte #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);
    localparam int            BW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shreg;
    logic          active;

    // Bit timing: counters only advance while a frame is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            done     <= 1'b0;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                tx       <= 1'b0;
                shreg    <= data;
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (active) begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    if (bit_cnt == 4'd9) begin
                        active  <= 1'b0;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd8) begin
                            tx <= 1'b1;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = active;

endmodule

// File: rtl/tx_print.sv
// Print stage for the debug command processors: sends one raw byte or a
// 32-bit word as 8 uppercase hex characters (MSB nibble first) over UART,
// then acknowledges the whole transfer with a single-cycle ack_tx.
module tx_print
    import debug_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic           clk,
    input  logic           rst,
    tx_print_if.slave      bus,
    output logic           tx
);
    localparam int DIV = CLK_FREQ / BAUD;

    tx_state_t   state;
    logic [31:0] din_q;
    logic        type_q;
    logic [2:0]  char_cnt;   // nibble index in word mode, 0 in byte mode

    logic [7:0]  ch_byte;
    logic        ser_start;
    logic        ser_done;
    logic        ser_busy;

    // Transfer sequencing; request inputs only matter while IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            din_q    <= '0;
            type_q   <= TX_TYPE_BYTE;
            char_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_tx) begin
                        din_q    <= bus.din_tx;
                        type_q   <= bus.type_tx;
                        char_cnt <= (bus.type_tx == TX_TYPE_WORD) ? 3'd7 : 3'd0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_SEND;
                ST_SEND: if (ser_done) state <= ST_NEXT;
                ST_NEXT: begin
                    if (char_cnt == 3'd0) begin
                        state <= ST_DONE;
                    end else begin
                        char_cnt <= char_cnt - 3'd1;
                        state    <= ST_LOAD;
                    end
                end
                ST_DONE: state <= ST_GAP;
                // One dead cycle so registered requesters can drop req_tx.
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Character select: raw low byte, or the current nibble as ASCII.
    always_comb begin
        ch_byte = din_q[7:0];
        if (type_q == TX_TYPE_WORD)
            ch_byte = hex_ascii(din_q[{char_cnt, 2'b00} +: 4]);
    end

    // Serializer is idle whenever LOAD is reached; the guard just keeps a
    // running frame from ever being restarted.
    assign ser_start = (state == ST_LOAD) && !ser_busy;

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .data  (ch_byte),
        .tx    (tx),
        .done  (ser_done),
        .busy  (ser_busy)
    );

    assign bus.ack_tx = (state == ST_DONE);
    assign bus.busy   = (state != ST_IDLE);

endmodule
